// File: rtl/mult_result_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_result_collector_pkg
// Description : State encoding and default sizing shared by the collector.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_result_collector_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_COLLECT = 3'd2,
        S_DONE    = 3'd3,
        S_ABORT   = 3'd4
    } state_t;

    localparam int c_NUM_DEFAULT     = 16;
    localparam int c_SUM_W_DEFAULT   = 20;
    localparam int c_TIMEOUT_DEFAULT = 1024;

endpackage
`default_nettype wire

// File: rtl/mult_result_collector_sat_accum.sv
`default_nettype none
// ============================================================================
// Module      : sat_accum
// Description : SUM_W-bit saturating adder of a 16-bit product, with carry-out
//               reported as the saturation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_accum
    import mult_result_collector_pkg::*;
#(
    parameter int SUM_W = c_SUM_W_DEFAULT
) (
    input  logic [SUM_W-1:0] i_acc,
    input  logic [15:0]      i_x,
    output logic [SUM_W-1:0] o_sum,
    output logic             o_sat
);

    logic [SUM_W:0] w_full;

    // One guard bit above the accumulator catches any true-sum overflow.
    assign w_full = {1'b0, i_acc} + {{(SUM_W + 1 - 16){1'b0}}, i_x};
    assign o_sat  = w_full[SUM_W];
    assign o_sum  = o_sat ? {SUM_W{1'b1}} : w_full[SUM_W-1:0];

endmodule
`default_nettype wire

// File: rtl/mult_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : mult_result_collector
// Description : Runs one batch of NUM products from the FIFO-multiplier stage,
//               reporting saturating sum, maximum and count, or aborting on stall.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_result_collector
    import mult_result_collector_pkg::*;
#(
    parameter int NUM     = c_NUM_DEFAULT,
    parameter int SUM_W   = c_SUM_W_DEFAULT,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic [15:0]      i_x,
    input  logic             i_x_valid,
    output logic             o_start,
    output logic             o_halt,
    output logic             o_busy,
    output logic [SUM_W-1:0] o_sum,
    output logic [15:0]      o_max,
    output logic [7:0]       o_count,
    output logic             o_sum_valid,
    output logic             o_ovf,
    output logic             o_err
);

    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    state_t             r_state;
    logic               r_start;
    logic               r_halt;
    logic               r_busy;
    logic [SUM_W-1:0]   r_sum;
    logic [15:0]        r_max;
    logic [7:0]         r_count;
    logic               r_sum_valid;
    logic               r_ovf;
    logic               r_err;
    logic [TMO_W-1:0]   r_tmo;

    logic [SUM_W-1:0]   w_sum_next;
    logic               w_sat;

    sat_accum #(
        .SUM_W (SUM_W)
    ) u_sat_accum (
        .i_acc (r_sum),
        .i_x   (i_x),
        .o_sum (w_sum_next),
        .o_sat (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_start     <= 1'b0;
            r_halt      <= 1'b0;
            r_busy      <= 1'b0;
            r_sum       <= '0;
            r_max       <= '0;
            r_count     <= '0;
            r_sum_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_start     <= 1'b0;
            r_halt      <= 1'b0;
            r_sum_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_run) begin
                        r_state <= S_ARM;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARM: begin
                    r_sum   <= '0;
                    r_max   <= '0;
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                    r_err   <= 1'b0;
                    r_tmo   <= '0;
                    r_state <= S_COLLECT;
                end
                S_COLLECT: begin
                    // A product arriving on the would-be timeout cycle still counts.
                    if (i_x_valid) begin
                        r_sum   <= w_sum_next;
                        r_ovf   <= r_ovf | w_sat;
                        r_count <= r_count + 8'd1;
                        r_tmo   <= '0;
                        if (i_x > r_max) begin
                            r_max <= i_x;
                        end
                        if (r_count == 8'(NUM - 1)) begin
                            r_state     <= S_DONE;
                            r_sum_valid <= 1'b1;
                        end
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                        if (r_tmo == TMO_W'(TIMEOUT - 2)) begin
                            r_state <= S_ABORT;
                            r_halt  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_ABORT: begin
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_start     = r_start;
    assign o_halt      = r_halt;
    assign o_busy      = r_busy;
    assign o_sum       = r_sum;
    assign o_max       = r_max;
    assign o_count     = r_count;
    assign o_sum_valid = r_sum_valid;
    assign o_ovf       = r_ovf;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mult_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_result_collector
// Description : Randomized self-checking bench; two instances (SUM_W 20 and 19)
//               share stimulus so saturation can be observed on the narrow one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_result_collector;

    localparam int NUM     = 16;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_run;
    logic [15:0] i_x;
    logic        i_x_valid;

    logic        o_start, o_halt, o_busy, o_sum_valid, o_ovf, o_err;
    logic [19:0] o_sum;
    logic [15:0] o_max;
    logic [7:0]  o_count;

    logic        o19_start, o19_halt, o19_busy, o19_sum_valid, o19_ovf, o19_err;
    logic [18:0] o19_sum;
    logic [15:0] o19_max;
    logic [7:0]  o19_count;

    int checks = 0;
    int errors = 0;

    mult_result_collector #(.NUM(NUM), .SUM_W(20), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_x(i_x), .i_x_valid(i_x_valid),
        .o_start(o_start), .o_halt(o_halt), .o_busy(o_busy), .o_sum(o_sum),
        .o_max(o_max), .o_count(o_count), .o_sum_valid(o_sum_valid),
        .o_ovf(o_ovf), .o_err(o_err)
    );

    mult_result_collector #(.NUM(NUM), .SUM_W(19), .TIMEOUT(TIMEOUT)) dut19 (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_x(i_x), .i_x_valid(i_x_valid),
        .o_start(o19_start), .o_halt(o19_halt), .o_busy(o19_busy), .o_sum(o19_sum),
        .o_max(o19_max), .o_count(o19_count), .o_sum_valid(o19_sum_valid),
        .o_ovf(o19_ovf), .o_err(o19_err)
    );

    always #5 clk = ~clk;

    // Pulse counters and end-of-batch snapshots, sampled on the falling edge.
    int          cyc = 0, n_start = 0, n_halt = 0, n_sv = 0, n_sv19 = 0;
    int          start_cyc = 0, prev_start_cyc = 0;
    logic [19:0] cap_sum = '0;
    logic [15:0] cap_max = '0;
    logic [7:0]  cap_count = '0;
    logic        cap_ovf = 1'b0;
    logic [18:0] cap19_sum = '0;
    logic        cap19_ovf = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (o_start) begin
            n_start        <= n_start + 1;
            prev_start_cyc <= start_cyc;
            start_cyc      <= cyc;
        end
        if (o_halt) n_halt <= n_halt + 1;
        if (o_sum_valid) begin
            n_sv      <= n_sv + 1;
            cap_sum   <= o_sum;
            cap_max   <= o_max;
            cap_count <= o_count;
            cap_ovf   <= o_ovf;
        end
        if (o19_sum_valid) begin
            n_sv19    <= n_sv19 + 1;
            cap19_sum <= o19_sum;
            cap19_ovf <= o19_ovf;
        end
    end

    // Reference: the saturating running sum of non-negative terms equals min(total, limit).
    task automatic model(input logic [15:0] v[$], input int w,
                         output longint s, output int m, output bit ovf);
        longint full = 0;
        longint lim  = (longint'(1) << w) - 1;
        m = 0;
        foreach (v[i]) begin
            full += longint'(v[i]);
            if (int'(v[i]) > m) m = int'(v[i]);
        end
        ovf = (full > lim);
        s   = ovf ? lim : full;
    endtask

    task automatic start_batch();
        i_run = 1'b1;
        @(posedge clk); #1;
        i_run = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic feed(input logic [15:0] v[$], input int max_gap);
        foreach (v[i]) begin
            i_x = v[i];
            i_x_valid = 1'b1;
            @(posedge clk); #1;
            i_x_valid = 1'b0;
            i_x = 16'($urandom);
            repeat ($urandom_range(max_gap, 0)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_run = 1'b0; i_x_valid = 1'b0; i_x = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_start, o_halt, o_busy, o_sum_valid} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {o_start, o_halt, o_busy, o_sum_valid});
        end
        checks++;
        if ({o_sum, o_max, o_count} !== '0) begin
            errors++; $display("FAIL reset_data: got sum %0d max %0d count %0d expected 0", o_sum, o_max, o_count);
        end
        checks++;
        if ({o_ovf, o_err} !== 2'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00", {o_ovf, o_err});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] v[$];
        longint es; int em; bit eo;
        int sv0 = n_sv, st0 = n_start, h0 = n_halt;
        for (int i = 1; i <= NUM; i++) v.push_back(16'(i));
        model(v, 20, es, em, eo);
        start_batch();
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", o_busy); end
        feed(v, 3);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (n_sv - sv0 != 1) begin errors++; $display("FAIL basic_sv_pulses: got %0d expected 1", n_sv - sv0); end
        checks++;
        if (longint'(cap_sum) !== es || es != 136) begin errors++; $display("FAIL basic_sum: got %0d expected 136", cap_sum); end
        checks++;
        if (int'(cap_max) !== em) begin errors++; $display("FAIL basic_max: got %0d expected %0d", cap_max, em); end
        checks++;
        if (cap_count !== 8'(NUM)) begin errors++; $display("FAIL basic_count: got %0d expected %0d", cap_count, NUM); end
        checks++;
        if ({cap_ovf, o_err} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b expected 00", {cap_ovf, o_err}); end
        checks++;
        if (n_start - st0 != 1 || n_halt != h0) begin
            errors++; $display("FAIL basic_pulses: got start %0d halt %0d expected 1 0", n_start - st0, n_halt - h0);
        end
        checks++;
        if (o_busy !== 1'b0 || o_sum !== cap_sum) begin
            errors++; $display("FAIL basic_idle_hold: got busy %b sum %0d expected 0 %0d", o_busy, o_sum, cap_sum);
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 3; b++) begin
            logic [15:0] v[$];
            longint es, es19; int em, em19; bit eo, eo19;
            int sv0 = n_sv;
            for (int i = 0; i < NUM; i++) v.push_back(16'($urandom));
            model(v, 20, es, em, eo);
            model(v, 19, es19, em19, eo19);
            start_batch();
            feed(v, 2);
            repeat (3) @(posedge clk); #1;
            checks++;
            if (n_sv - sv0 != 1 || longint'(cap_sum) !== es || int'(cap_max) !== em || cap_count !== 8'(NUM)) begin
                errors++;
                $display("FAIL random_w20: got sv %0d sum %0d max %0d count %0d expected 1 %0d %0d %0d",
                         n_sv - sv0, cap_sum, cap_max, cap_count, es, em, NUM);
            end
            checks++;
            if (longint'(cap19_sum) !== es19 || cap19_ovf !== eo19) begin
                errors++; $display("FAIL random_w19: got sum %0d ovf %b expected %0d %b", cap19_sum, cap19_ovf, es19, eo19);
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] v[$];
        for (int i = 0; i < NUM; i++) v.push_back(16'hFFFF);
        start_batch();
        feed(v, 0);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (cap_sum !== 20'd1048560 || cap_ovf !== 1'b0) begin
            errors++; $display("FAIL sat_w20: got sum %0d ovf %b expected 1048560 0", cap_sum, cap_ovf);
        end
        checks++;
        if (cap19_sum !== 19'd524287 || cap19_ovf !== 1'b1) begin
            errors++; $display("FAIL sat_w19: got sum %0d ovf %b expected 524287 1", cap19_sum, cap19_ovf);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] v[$];
        longint es; int em; bit eo;
        int sv0 = n_sv, h0 = n_halt, k = 0;
        for (int i = 0; i < 5; i++) v.push_back(16'($urandom_range(1000, 0)));
        model(v, 20, es, em, eo);
        start_batch();
        feed(v, 3);
        while (n_halt == h0 && k < TIMEOUT + 8) begin
            @(negedge clk); k++;
        end
        repeat (5) @(posedge clk); #1;
        checks++;
        if (n_halt - h0 != 1) begin errors++; $display("FAIL timeout_halt_count: got %0d expected 1", n_halt - h0); end
        checks++;
        if (k < TIMEOUT - 8) begin errors++; $display("FAIL timeout_early: got %0d cycles expected >= %0d", k, TIMEOUT - 8); end
        checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b0) begin
            errors++; $display("FAIL timeout_err: got err %b busy %b expected 1 0", o_err, o_busy);
        end
        checks++;
        if (o_count !== 8'd5 || longint'(o_sum) !== es || int'(o_max) !== em) begin
            errors++; $display("FAIL timeout_partial: got count %0d sum %0d max %0d expected 5 %0d %0d", o_count, o_sum, o_max, es, em);
        end
        checks++;
        if (n_sv != sv0) begin errors++; $display("FAIL timeout_no_sv: got %0d expected 0", n_sv - sv0); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v1[$], v2[$];
        longint es, es19; int em, em19; bit eo, eo19;
        int sv0 = n_sv, st0 = n_start, k;
        for (int i = 0; i < NUM; i++) begin
            v1.push_back(16'hFFFF);
            v2.push_back(16'($urandom));
        end
        model(v2, 20, es, em, eo);
        model(v2, 19, es19, em19, eo19);
        i_run = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!o_start && k < 10);
        checks++;
        if (o_start !== 1'b1) begin errors++; $display("FAIL b2b_start1: got %b expected 1", o_start); end
        @(negedge clk);
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL b2b_err_clear: got %b expected 0", o_err); end
        feed(v1, 0);
        k = 0;
        do begin @(negedge clk); k++; end while (!o_start && k < 10);
        i_run = 1'b0;
        checks++;
        if (o_start !== 1'b1 || o19_ovf !== 1'b1) begin
            errors++; $display("FAIL b2b_start2: got start %b ovf19 %b expected 1 1", o_start, o19_ovf);
        end
        @(negedge clk);
        checks++;
        if (o19_ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf_clear: got %b expected 0", o19_ovf); end
        feed(v2, 1);
        repeat (4) @(posedge clk); #1;
        checks++;
        if (n_start - st0 != 2 || n_sv - sv0 != 2) begin
            errors++; $display("FAIL b2b_pulses: got start %0d sv %0d expected 2 2", n_start - st0, n_sv - sv0);
        end
        checks++;
        if (start_cyc - prev_start_cyc < 3) begin
            errors++; $display("FAIL b2b_gap: got %0d expected >= 3", start_cyc - prev_start_cyc);
        end
        checks++;
        if (longint'(cap_sum) !== es || int'(cap_max) !== em || longint'(cap19_sum) !== es19 || cap19_ovf !== eo19) begin
            errors++; $display("FAIL b2b_result: got %0d %0d %0d %b expected %0d %0d %0d %b",
                               cap_sum, cap_max, cap19_sum, cap19_ovf, es, em, es19, eo19);
        end
    endtask

    task automatic test_ignore();
        logic [15:0] v[$];
        longint es; int em; bit eo;
        logic [7:0]  c_prev = o_count;
        logic [19:0] s_prev = o_sum;
        i_x_valid = 1'b1;
        repeat (4) begin
            i_x = 16'($urandom);
            @(posedge clk); #1;
        end
        checks++;
        if (o_count !== c_prev || o_sum !== s_prev) begin
            errors++; $display("FAIL ignore_idle: got count %0d sum %0d expected %0d %0d", o_count, o_sum, c_prev, s_prev);
        end
        i_run = 1'b1;
        @(posedge clk); #1;
        i_run = 1'b0;
        @(posedge clk); #1;
        i_x_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_count !== 8'd0 || o_sum !== 20'd0) begin
            errors++; $display("FAIL ignore_arm: got count %0d sum %0d expected 0 0", o_count, o_sum);
        end
        for (int i = 0; i < NUM; i++) v.push_back(16'($urandom));
        model(v, 20, es, em, eo);
        feed(v, 1);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (cap_count !== 8'(NUM) || longint'(cap_sum) !== es) begin
            errors++; $display("FAIL ignore_batch: got count %0d sum %0d expected %0d %0d", cap_count, cap_sum, NUM, es);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v[$], w[$];
        longint es; int em; bit eo;
        int sv0, h0;
        for (int i = 0; i < 7; i++) v.push_back(16'($urandom));
        start_batch();
        feed(v, 2);
        sv0 = n_sv; h0 = n_halt;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_start, o_halt, o_sum_valid, o_ovf, o_err} !== 6'b0 || {o_sum, o_max, o_count} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got busy %b sum %0d max %0d count %0d expected all 0",
                               o_busy, o_sum, o_max, o_count);
        end
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (n_sv != sv0 || n_halt != h0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL midreset_pulses: got sv %0d halt %0d busy %b expected 0 0 0", n_sv - sv0, n_halt - h0, o_busy);
        end
        for (int i = 0; i < NUM; i++) w.push_back(16'($urandom));
        model(w, 20, es, em, eo);
        start_batch();
        feed(w, 3);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (n_sv - sv0 != 1 || longint'(cap_sum) !== es || int'(cap_max) !== em || cap_count !== 8'(NUM)) begin
            errors++; $display("FAIL midreset_rerun: got sv %0d sum %0d max %0d count %0d expected 1 %0d %0d %0d",
                               n_sv - sv0, cap_sum, cap_max, cap_count, es, em, NUM);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_saturation();
        test_timeout();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
